// File: rtl/bus_arbiter_if.sv
// Bus arbiter request/grant bundle: the masters drive requests, the arbiter returns the grant.
interface bus_arbiter_if #(
    parameter int NREQ = 4
);
    logic [2*NREQ-1:0] req;
    logic [2*NREQ-1:0] len;
    logic              ackin;
    logic [NREQ-1:0]   gnt;
    logic [1:0]        owner;
    logic              busy;
    logic [2:0]        beats_left;
    logic              timeout_err;

    modport master (output req, len, ackin,
                    input  gnt, owner, busy, beats_left, timeout_err);
    modport slave  (input  req, len, ackin,
                    output gnt, owner, busy, beats_left, timeout_err);
endinterface

// File: rtl/bus_arbiter.sv
// Priority/round-robin bus arbiter with aging, burst hold, abort, ack timeout and a turnaround cycle.
module bus_arbiter_age #(
    parameter int AGE_LIMIT = 15,
    parameter int AW        = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          active,
    input  logic          granted,
    output logic [AW-1:0] age
);
    always_ff @(posedge clk) begin
        if (reset || !active || granted)
            age <= '0;
        else if (age != AW'(AGE_LIMIT))
            age <= age + AW'(1);
    end
endmodule

module bus_arbiter #(
    parameter int NREQ      = 4,
    parameter int AGE_LIMIT = 15,
    parameter int TIMEOUT   = 63
) (
    input  logic            clk,
    input  logic            reset,
    bus_arbiter_if.slave    bus
);
    localparam int AW = $clog2(AGE_LIMIT + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] TURN = 2'd2;

    logic [1:0]               st;
    logic [NREQ-1:0]          gnt_q;
    logic [1:0]               owner_q;
    logic [2:0]               beats_q;
    logic                     terr_q;
    logic [1:0]               rr_last;
    logic [WW-1:0]            wait_cnt;
    logic [NREQ-1:0][AW-1:0]  age;
    logic [NREQ-1:0][1:0]     eff;
    logic [NREQ-1:0]          win_oh;
    logic [1:0]               winner;
    logic [1:0]               best_p;
    logic [1:0]               len_w;
    logic [1:0]               owner_req;
    logic                     grant_now;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        logic [1:0] r;
        assign r = bus.req[2*i +: 2];
        // An aged request only counts as urgent while it is still asserted.
        assign eff[i] = (r != 2'd0 && age[i] == AW'(AGE_LIMIT)) ? 2'd3 : r;

        bus_arbiter_age #(.AGE_LIMIT(AGE_LIMIT), .AW(AW)) u_age (
            .clk     (clk),
            .reset   (reset),
            .active  (r != 2'd0),
            .granted (gnt_q[i] || (grant_now && win_oh[i])),
            .age     (age[i])
        );
    end

    // Walk from rr_last+1; strict '>' keeps the first tied requester in rotation order.
    always_comb begin
        int idx;
        winner = '0;
        best_p = '0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(rr_last) + k) % NREQ;
            if (eff[idx] > best_p) begin
                best_p = eff[idx];
                winner = idx[1:0];
            end
        end
    end

    always_comb begin
        win_oh = '0;
        for (int i = 0; i < NREQ; i++)
            win_oh[i] = (winner == 2'(i));
    end

    assign grant_now = (st == IDLE) && (best_p != 2'd0);
    assign len_w     = bus.len[{winner, 1'b0} +: 2];
    assign owner_req = bus.req[{owner_q, 1'b0} +: 2];

    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= IDLE;
            gnt_q    <= '0;
            owner_q  <= '0;
            beats_q  <= '0;
            terr_q   <= 1'b0;
            rr_last  <= 2'(NREQ - 1);
            wait_cnt <= '0;
        end else begin
            terr_q <= 1'b0;
            case (st)
                IDLE: begin
                    if (grant_now) begin
                        gnt_q    <= win_oh;
                        owner_q  <= winner;
                        beats_q  <= {1'b0, len_w} + 3'd1;
                        rr_last  <= winner;
                        wait_cnt <= '0;
                        st       <= BUSY;
                    end
                end
                BUSY: begin
                    // Withdrawal outranks a same-cycle ack.
                    if (owner_req == 2'd0) begin
                        gnt_q    <= '0;
                        beats_q  <= '0;
                        wait_cnt <= '0;
                        st       <= TURN;
                    end else if (bus.ackin) begin
                        wait_cnt <= '0;
                        if (beats_q == 3'd1) begin
                            gnt_q   <= '0;
                            beats_q <= '0;
                            st      <= TURN;
                        end else begin
                            beats_q <= beats_q - 3'd1;
                        end
                    end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                        gnt_q    <= '0;
                        beats_q  <= '0;
                        wait_cnt <= '0;
                        terr_q   <= 1'b1;
                        st       <= TURN;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                TURN:    st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.owner       = owner_q;
    assign bus.busy        = |gnt_q;
    assign bus.beats_left  = beats_q;
    assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vectors, corner sequences and a random run against a spec-level model.
module tb_bus_arbiter;
    localparam int AGE_LIMIT = 15;
    localparam int TIMEOUT   = 63;

    logic clk;
    logic reset;
    int   total;
    int   passed;

    bus_arbiter_if #(.NREQ(4)) bus ();

    bus_arbiter #(.NREQ(4), .AGE_LIMIT(AGE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: whole-burst view with owner index, beats remaining and a turnaround flag.
    int m_owner, m_beats, m_wait, m_rr, m_last;
    bit m_turn, m_terr;
    int m_age [4];

    function automatic void model_reset();
        m_owner = -1; m_beats = 0; m_wait = 0; m_rr = 3; m_last = 0;
        m_turn = 1'b0; m_terr = 1'b0;
        for (int i = 0; i < 4; i++) m_age[i] = 0;
    endfunction

    function automatic void model_release();
        m_owner = -1; m_beats = 0; m_wait = 0; m_turn = 1'b1;
    endfunction

    function automatic void model_step(logic [7:0] r, logic [7:0] l, logic a);
        int pr [4];
        int ep [4];
        int maxp, win, bestd, d;
        for (int i = 0; i < 4; i++) begin
            pr[i] = int'(r[2*i +: 2]);
            ep[i] = (pr[i] != 0 && m_age[i] == AGE_LIMIT) ? 3 : pr[i];
        end
        win = -1;
        if (m_owner < 0 && !m_turn) begin
            maxp = 0;
            for (int i = 0; i < 4; i++) if (ep[i] > maxp) maxp = ep[i];
            bestd = 99;
            if (maxp > 0)
                for (int i = 0; i < 4; i++)
                    if (ep[i] == maxp) begin
                        d = (i - m_rr - 1 + 8) % 4;
                        if (d < bestd) begin bestd = d; win = i; end
                    end
        end
        for (int i = 0; i < 4; i++)
            m_age[i] = (pr[i] == 0 || i == m_owner || i == win) ? 0 :
                       (m_age[i] < AGE_LIMIT ? m_age[i] + 1 : AGE_LIMIT);
        m_terr = 1'b0;
        if (m_owner >= 0) begin
            if (pr[m_owner] == 0) model_release();
            else if (a) begin
                m_wait = 0;
                m_beats--;
                if (m_beats == 0) model_release();
            end else begin
                m_wait++;
                if (m_wait == TIMEOUT) begin model_release(); m_terr = 1'b1; end
            end
        end else if (m_turn) begin
            m_turn = 1'b0;
        end else if (win >= 0) begin
            m_owner = win; m_last = win; m_rr = win;
            m_beats = int'(l[2*win +: 2]) + 1;
            m_wait  = 0;
        end
    endfunction

    function automatic logic [31:0] exp_vec();
        logic [3:0] g;
        g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
        return 32'({g, 2'(m_last), (m_owner >= 0), 3'(m_beats), m_terr});
    endfunction

    function automatic logic [31:0] dut_vec();
        return 32'({bus.gnt, bus.owner, bus.busy, bus.beats_left, bus.timeout_err});
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step(input logic [7:0] r, input logic [7:0] l, input logic a);
        bus.req = r; bus.len = l; bus.ackin = a;
        @(posedge clk);
        if (reset) model_reset();
        else model_step(r, l, a);
        #1;
        check("model", dut_vec(), exp_vec());
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(8'h00, 8'h00, 1'b0);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [7:0] req;
        logic [7:0] len;
        logic       ack;
        logic [3:0] gnt;
        logic [1:0] own;
        logic       busy;
        logic [2:0] beats;
        logic       terr;
    } vec_t;

    vec_t tbl [15];
    logic [7:0] rnd_req;
    int n, n3, at, cnt, terr_n;
    bit prev_busy, got0;
    int order [5];
    int tg    [5];

    initial begin
        total = 0; passed = 0;
        reset = 1'b0;
        bus.req = '0; bus.len = '0; bus.ackin = 1'b0;
        model_reset();

        // single requester, turnaround, abort, priority, ack while idle
        tbl[0]  = '{8'h08, 8'h0C, 1'b0, 4'b0010, 2'd1, 1'b1, 3'd4, 1'b0};
        tbl[1]  = '{8'h08, 8'h0C, 1'b1, 4'b0010, 2'd1, 1'b1, 3'd3, 1'b0};
        tbl[2]  = '{8'h08, 8'h0C, 1'b1, 4'b0010, 2'd1, 1'b1, 3'd2, 1'b0};
        tbl[3]  = '{8'h08, 8'h0C, 1'b1, 4'b0010, 2'd1, 1'b1, 3'd1, 1'b0};
        tbl[4]  = '{8'h08, 8'h0C, 1'b1, 4'b0000, 2'd1, 1'b0, 3'd0, 1'b0};
        tbl[5]  = '{8'h08, 8'h0C, 1'b1, 4'b0000, 2'd1, 1'b0, 3'd0, 1'b0};
        tbl[6]  = '{8'h08, 8'h0C, 1'b0, 4'b0010, 2'd1, 1'b1, 3'd4, 1'b0};
        tbl[7]  = '{8'h00, 8'h0C, 1'b1, 4'b0000, 2'd1, 1'b0, 3'd0, 1'b0};
        tbl[8]  = '{8'h00, 8'h00, 1'b0, 4'b0000, 2'd1, 1'b0, 3'd0, 1'b0};
        tbl[9]  = '{8'h31, 8'h00, 1'b0, 4'b0100, 2'd2, 1'b1, 3'd1, 1'b0};
        tbl[10] = '{8'h31, 8'h00, 1'b1, 4'b0000, 2'd2, 1'b0, 3'd0, 1'b0};
        tbl[11] = '{8'h01, 8'h00, 1'b0, 4'b0000, 2'd2, 1'b0, 3'd0, 1'b0};
        tbl[12] = '{8'h01, 8'h00, 1'b0, 4'b0001, 2'd0, 1'b1, 3'd1, 1'b0};
        tbl[13] = '{8'h01, 8'h00, 1'b1, 4'b0000, 2'd0, 1'b0, 3'd0, 1'b0};
        tbl[14] = '{8'h00, 8'h00, 1'b1, 4'b0000, 2'd0, 1'b0, 3'd0, 1'b0};

        do_reset();
        check("reset_state", dut_vec(), 32'h0);

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].req, tbl[i].len, tbl[i].ack);
            check($sformatf("vec%0d", i), dut_vec(),
                  32'({tbl[i].gnt, tbl[i].own, tbl[i].busy, tbl[i].beats, tbl[i].terr}));
        end

        // round-robin among four equal requesters
        do_reset();
        n = 0; prev_busy = 1'b0;
        for (int i = 0; i < 5; i++) begin order[i] = 7; tg[i] = -100; end
        for (int c = 0; c < 20 && n < 5; c++) begin
            step(8'hAA, 8'h00, 1'b1);
            if (bus.busy && !prev_busy) begin order[n] = int'(bus.owner); tg[n] = c; n++; end
            prev_busy = bus.busy;
        end
        check("rr_count", 32'(n), 32'd5);
        for (int i = 0; i < 5; i++) check($sformatf("rr_owner%0d", i), 32'(order[i]), 32'(i % 4));
        for (int i = 1; i < 5; i++) check($sformatf("rr_gap%0d", i), 32'(tg[i] - tg[i-1]), 32'd3);

        // aging: low-priority requester 0 eventually ties and wins the rotation
        do_reset();
        n3 = 0; got0 = 1'b0; at = -1; prev_busy = 1'b0;
        for (int c = 0; c < 60 && !got0; c++) begin
            step(8'hC1, 8'hC0, 1'b1);
            if (bus.busy && !prev_busy) begin
                if (bus.owner == 2'd3) n3++;
                else if (bus.owner == 2'd0) begin got0 = 1'b1; at = c; end
            end
            prev_busy = bus.busy;
        end
        check("age_grants_to_3", 32'(n3), 32'd3);
        check("age_win_cycle", 32'(at), 32'd18);

        // ack timeout
        do_reset();
        step(8'h08, 8'h0C, 1'b0);
        check("to_grant", 32'(bus.gnt), 32'b0010);
        cnt = 0; terr_n = 0;
        while (bus.busy && cnt < 100) begin
            step(8'h08, 8'h0C, 1'b0);
            cnt++;
            if (bus.timeout_err) terr_n++;
        end
        check("to_cycles", 32'(cnt), 32'(TIMEOUT));
        check("to_err_at_release", 32'(bus.timeout_err), 32'd1);
        step(8'h08, 8'h0C, 1'b0);
        check("to_err_one_cycle", 32'(bus.timeout_err), 32'd0);
        check("to_pulse_count", 32'(terr_n), 32'd1);

        // withdrawal mid-burst
        do_reset();
        step(8'h08, 8'h0C, 1'b0);
        step(8'h08, 8'h0C, 1'b1);
        step(8'h00, 8'h0C, 1'b0);
        check("abort_gnt", 32'(bus.gnt), 32'd0);
        check("abort_no_err", 32'(bus.timeout_err), 32'd0);

        // reset mid-burst, then the tie goes to requester 0
        do_reset();
        step(8'h02, 8'h03, 1'b0);
        step(8'h02, 8'h03, 1'b1);
        step(8'h02, 8'h03, 1'b1);
        check("rstmid_beats", 32'(bus.beats_left), 32'd2);
        reset = 1'b1;
        step(8'h0A, 8'h03, 1'b1);
        reset = 1'b0;
        check("rstmid_outputs", dut_vec(), 32'h0);
        step(8'h0A, 8'h03, 1'b0);
        check("rstmid_first_grant", 32'(bus.gnt), 32'b0001);
        check("rstmid_beats_after", 32'(bus.beats_left), 32'd4);

        // random traffic with stretches of rare acks to provoke timeouts
        do_reset();
        rnd_req = '0;
        for (int c = 0; c < 3000; c++) begin
            logic a;
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 7) == 0) rnd_req[2*i +: 2] = 2'($urandom_range(0, 3));
            if ((c % 600) >= 450) a = ($urandom_range(0, 49) == 0);
            else a = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 399) == 0) reset = 1'b1;
            step(rnd_req, 8'($urandom), a);
            reset = 1'b0;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
